tag_lookup_seq: RTL and testbench
=================================

TAG_LOOKUP_SEQ -- requirements
Module: tag_lookup_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: tag width, matches CAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: CAM address width.
REQ-003 SHALL have parameter NUM_TAGS, default 8: tag table depth (power of 2); TID_W = log2(NUM_TAGS).
REQ-004 SHALL have parameter SEARCH_LAT, default 1: cycles from cam_search_o pulse to valid cam_match_i/cam_index_i (range 1..4).
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports listed below.
REQ-006 Ports (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 rst_n  in  1  async active-low reset
 tag_wr_i  in  1  write tag table entry
 tag_wr_idx_i  in  TID_W  entry index
 tag_wr_data_i  in  DATA_WIDTH  tag value
 tag_wr_en_i  in  1  entry enable bit written alongside tag
 tag_wr_err_o  out  1  one-cycle pulse: write dropped (busy)
 msg_valid_i  in  1  message window offered
 msg_start_i  in  ADDR_WIDTH  window start address
 msg_end_i  in  ADDR_WIDTH  window end address
 msg_ready_o  out  1  window accepted when valid&ready
 cam_search_o  out  1  CAM search strobe
 cam_find_tag_o  out  DATA_WIDTH  tag searched
 cam_start_index_o  out  ADDR_WIDTH  search window start
 cam_end_index_o  out  ADDR_WIDTH  search window end
 cam_match_i  in  1  CAM match flag
 cam_index_i  in  ADDR_WIDTH  CAM match index
 res_valid_o  out  1  result valid
 res_ready_i  in  1  result consumer ready
 res_tag_id_o  out  TID_W  tag table entry of result
 res_found_o  out  1  tag found in window
 res_index_o  out  ADDR_WIDTH  match index (0 if not found)
 busy_o  out  1  lookup in progress
 done_o  out  1  one-cycle pulse: all entries processed

Function
REQ-007 SHALL implement FSM IDLE, ISSUE, WAIT, EMIT, DONE.
REQ-008 IDLE: msg_ready_o=1; on msg_valid_i, latch start/end, set entry pointer to lowest enabled entry; go ISSUE, or DONE if no entry enabled.
REQ-009 ISSUE: cam_search_o=1 for exactly one cycle with cam_find_tag_o=table[ptr], window=latched start/end; go WAIT.
REQ-010 WAIT: count SEARCH_LAT cycles after strobe; sample cam_match_i/cam_index_i on the SEARCH_LAT-th cycle after the strobe; go EMIT.
REQ-011 EMIT: res_valid_o=1, outputs held stable until res_valid_o&res_ready_i; then advance ptr to next enabled entry (ISSUE) or go DONE if none remain.
REQ-012 res_index_o SHALL be 0 when res_found_o=0.
REQ-013 DONE: done_o=1 for one cycle, return to IDLE.
REQ-014 Disabled entries SHALL be skipped with no search and no result; results emitted in ascending entry order.
REQ-015 Window with start > end SHALL be forwarded unchanged (wrap handled by CAM).
REQ-016 cam_find_tag_o/window outputs SHALL be 0 whenever cam_search_o=0.
REQ-017 Tag writes in IDLE SHALL update entry next cycle; writes when busy_o=1 SHALL be dropped and pulse tag_wr_err_o.
REQ-018 A tag write coincident with msg acceptance SHALL be dropped and flagged (table frozen at acceptance).
REQ-019 busy_o=1 in every state except IDLE; msg_ready_o=0 when busy.
REQ-020 Per-entry latency without backpressure: 2+SEARCH_LAT cycles; acceptance to first strobe: 1 cycle.

Reset
REQ-021 On rst_n low (asynchronous): FSM=IDLE, all table tags and enables=0, pointer=0, counters=0, all outputs 0 except msg_ready_o=1 after release.
REQ-022 Reset mid-lookup SHALL abort immediately with no done_o pulse and no further results.

Structure
REQ-023 Shared package SHALL hold the FSM state enum and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-024 Tag table (NUM_TAGS x (DATA_WIDTH+1) regs with find-next-enabled logic) SHALL be sub-module tag_lookup_table.

Verification
REQ-025 Tags {0x3D38,0x3539} in entries 0,1 enabled; window 3..17; CAM matches entry0 at 7, entry1 none -> results (0,1,7),(1,0,0), done_o 1 cycle after second handshake.
REQ-026 Only entry 5 enabled -> exactly one cam_search_o pulse with table[5]; one result id 5.
REQ-027 res_ready_i low 10 cycles in EMIT -> res_* stable, no new cam_search_o until handshake.
REQ-028 No entries enabled, msg_valid_i -> no search, done_o 2 cycles after acceptance.
REQ-029 tag_wr_i during WAIT -> tag_wr_err_o pulse, table unchanged on next lookup.
REQ-030 rst_n asserted in WAIT -> outputs 0 same cycle, no done_o; start=20,end=4 lookup afterward -> window forwarded as 20/4.

Source files
------------

// File: rtl/tag_lookup_seq_pkg.sv
// Shared types and default widths for the tag lookup sequencer.
package tag_lookup_seq_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    // Lookup sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/tag_lookup_seq_table.sv
// Tag table: NUM_TAGS entries of {enable, tag} with find-first and
// find-next-enabled lookups used to walk the enabled entries in order.
module tag_lookup_table
    import tag_lookup_seq_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_TAGS   = 8,
    localparam int TID_W      = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [TID_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic [TID_W-1:0]      cur_idx,
    output logic                  first_found,
    output logic [TID_W-1:0]      first_idx,
    output logic [DATA_WIDTH-1:0] first_tag,
    output logic                  next_found,
    output logic [TID_W-1:0]      next_idx,
    output logic [DATA_WIDTH-1:0] next_tag
);

    logic [DATA_WIDTH-1:0] tag_r [NUM_TAGS];
    logic [NUM_TAGS-1:0]   en_r;

    // Table storage: cleared on reset, one entry written per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                tag_r[i] <= '0;
            end
            en_r <= '0;
        end else if (wr) begin
            tag_r[wr_idx] <= wr_data;
            en_r[wr_idx]  <= wr_en;
        end
    end

    // Priority search from the top down so the lowest matching index wins.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            first_found = en_r[i] ? 1'b1 : first_found;
            first_idx   = en_r[i] ? TID_W'(i) : first_idx;
            next_found  = (en_r[i] && (TID_W'(i) > cur_idx)) ? 1'b1 : next_found;
            next_idx    = (en_r[i] && (TID_W'(i) > cur_idx)) ? TID_W'(i) : next_idx;
        end
    end

    assign first_tag = tag_r[first_idx];
    assign next_tag  = tag_r[next_idx];

endmodule

// File: rtl/tag_lookup_seq.sv
// Tag lookup sequencer: on each accepted message window, searches the CAM
// once per enabled tag-table entry (ascending order) and emits one result
// per search through a valid/ready handshake, then pulses done.
module tag_lookup_seq
    import tag_lookup_seq_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int  NUM_TAGS   = 8,
    parameter int  SEARCH_LAT = 1,
    localparam int TID_W      = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tag_wr_i,
    input  logic [TID_W-1:0]      tag_wr_idx_i,
    input  logic [DATA_WIDTH-1:0] tag_wr_data_i,
    input  logic                  tag_wr_en_i,
    output logic                  tag_wr_err_o,
    input  logic                  msg_valid_i,
    input  logic [ADDR_WIDTH-1:0] msg_start_i,
    input  logic [ADDR_WIDTH-1:0] msg_end_i,
    output logic                  msg_ready_o,
    output logic                  cam_search_o,
    output logic [DATA_WIDTH-1:0] cam_find_tag_o,
    output logic [ADDR_WIDTH-1:0] cam_start_index_o,
    output logic [ADDR_WIDTH-1:0] cam_end_index_o,
    input  logic                  cam_match_i,
    input  logic [ADDR_WIDTH-1:0] cam_index_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [TID_W-1:0]      res_tag_id_o,
    output logic                  res_found_o,
    output logic [ADDR_WIDTH-1:0] res_index_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Last WAIT cycle: the CAM answer is valid SEARCH_LAT cycles after the strobe.
    localparam logic [2:0] LAT_LAST = 3'(SEARCH_LAT);

    state_t                state_r;
    logic [TID_W-1:0]      ptr_r;
    logic [ADDR_WIDTH-1:0] start_r;
    logic [ADDR_WIDTH-1:0] end_r;
    logic [2:0]            lat_cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  tag_wr_err_r;
    logic                  cam_search_r;
    logic [DATA_WIDTH-1:0] cam_find_tag_r;
    logic [ADDR_WIDTH-1:0] cam_start_r;
    logic [ADDR_WIDTH-1:0] cam_end_r;
    logic                  res_valid_r;
    logic [TID_W-1:0]      res_tag_id_r;
    logic                  res_found_r;
    logic [ADDR_WIDTH-1:0] res_index_r;

    logic                  wr_accept_s;
    logic                  first_found_s;
    logic [TID_W-1:0]      first_idx_s;
    logic [DATA_WIDTH-1:0] first_tag_s;
    logic                  next_found_s;
    logic [TID_W-1:0]      next_idx_s;
    logic [DATA_WIDTH-1:0] next_tag_s;

    // The table is frozen from acceptance on: a write in the acceptance
    // cycle or while busy is dropped.
    assign wr_accept_s = tag_wr_i & ~busy_r & ~msg_valid_i;

    tag_lookup_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAGS   (NUM_TAGS)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr_accept_s),
        .wr_idx      (tag_wr_idx_i),
        .wr_data     (tag_wr_data_i),
        .wr_en       (tag_wr_en_i),
        .cur_idx     (ptr_r),
        .first_found (first_found_s),
        .first_idx   (first_idx_s),
        .first_tag   (first_tag_s),
        .next_found  (next_found_s),
        .next_idx    (next_idx_s),
        .next_tag    (next_tag_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            ptr_r          <= '0;
            start_r        <= '0;
            end_r          <= '0;
            lat_cnt_r      <= 3'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            tag_wr_err_r   <= 1'b0;
            cam_search_r   <= 1'b0;
            cam_find_tag_r <= '0;
            cam_start_r    <= '0;
            cam_end_r      <= '0;
            res_valid_r    <= 1'b0;
            res_tag_id_r   <= '0;
            res_found_r    <= 1'b0;
            res_index_r    <= '0;
        end else begin
            tag_wr_err_r <= tag_wr_i & ~wr_accept_s;
            case (state_r)
                ST_IDLE: begin
                    if (msg_valid_i) begin
                        start_r <= msg_start_i;
                        end_r   <= msg_end_i;
                        busy_r  <= 1'b1;
                        if (first_found_s) begin
                            ptr_r          <= first_idx_s;
                            cam_search_r   <= 1'b1;
                            cam_find_tag_r <= first_tag_s;
                            cam_start_r    <= msg_start_i;
                            cam_end_r      <= msg_end_i;
                            state_r        <= ST_ISSUE;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cam_search_r   <= 1'b0;
                    cam_find_tag_r <= '0;
                    cam_start_r    <= '0;
                    cam_end_r      <= '0;
                    lat_cnt_r      <= 3'd1;
                    state_r        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt_r >= LAT_LAST) begin
                        res_valid_r  <= 1'b1;
                        res_tag_id_r <= ptr_r;
                        res_found_r  <= cam_match_i;
                        res_index_r  <= cam_match_i ? cam_index_i : '0;
                        lat_cnt_r    <= 3'd0;
                        state_r      <= ST_EMIT;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                ST_EMIT: begin
                    if (res_ready_i) begin
                        res_valid_r  <= 1'b0;
                        res_tag_id_r <= '0;
                        res_found_r  <= 1'b0;
                        res_index_r  <= '0;
                        if (next_found_s) begin
                            ptr_r          <= next_idx_s;
                            cam_search_r   <= 1'b1;
                            cam_find_tag_r <= next_tag_s;
                            cam_start_r    <= start_r;
                            cam_end_r      <= end_r;
                            state_r        <= ST_ISSUE;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Entered with done already set after a result; from IDLE
                    // (nothing enabled) it takes one extra cycle to raise it.
                    if (done_r) begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        ptr_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    cam_search_r <= 1'b0;
                    res_valid_r  <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign msg_ready_o       = ~busy_r;
    assign busy_o            = busy_r;
    assign done_o            = done_r;
    assign tag_wr_err_o      = tag_wr_err_r;
    assign cam_search_o      = cam_search_r;
    assign cam_find_tag_o    = cam_find_tag_r;
    assign cam_start_index_o = cam_start_r;
    assign cam_end_index_o   = cam_end_r;
    assign res_valid_o       = res_valid_r;
    assign res_tag_id_o      = res_tag_id_r;
    assign res_found_o       = res_found_r;
    assign res_index_o       = res_index_r;

endmodule

// File: tb/tb_tag_lookup_seq.sv
// Directed bench for tag_lookup_seq with a one-cycle-latency CAM model.
module tb_tag_lookup_seq;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NT = 8;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tag_wr_i = 1'b0;
    logic [TW-1:0] tag_wr_idx_i = '0;
    logic [DW-1:0] tag_wr_data_i = '0;
    logic          tag_wr_en_i = 1'b0;
    logic          tag_wr_err_o;
    logic          msg_valid_i = 1'b0;
    logic [AW-1:0] msg_start_i = '0;
    logic [AW-1:0] msg_end_i = '0;
    logic          msg_ready_o;
    logic          cam_search_o;
    logic [DW-1:0] cam_find_tag_o;
    logic [AW-1:0] cam_start_index_o;
    logic [AW-1:0] cam_end_index_o;
    logic          cam_match_i = 1'b0;
    logic [AW-1:0] cam_index_i = '0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [TW-1:0] res_tag_id_o;
    logic          res_found_o;
    logic [AW-1:0] res_index_o;
    logic          busy_o;
    logic          done_o;

    int n_vec = 0;
    int n_err = 0;
    int strobes = 0;
    int s0 = 0;
    int cyc = 0;
    logic          pend = 1'b0;
    logic [DW-1:0] ptag = '0;

    tag_lookup_seq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_TAGS   (NT),
        .SEARCH_LAT (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tag_wr_i          (tag_wr_i),
        .tag_wr_idx_i      (tag_wr_idx_i),
        .tag_wr_data_i     (tag_wr_data_i),
        .tag_wr_en_i       (tag_wr_en_i),
        .tag_wr_err_o      (tag_wr_err_o),
        .msg_valid_i       (msg_valid_i),
        .msg_start_i       (msg_start_i),
        .msg_end_i         (msg_end_i),
        .msg_ready_o       (msg_ready_o),
        .cam_search_o      (cam_search_o),
        .cam_find_tag_o    (cam_find_tag_o),
        .cam_start_index_o (cam_start_index_o),
        .cam_end_index_o   (cam_end_index_o),
        .cam_match_i       (cam_match_i),
        .cam_index_i       (cam_index_i),
        .res_valid_o       (res_valid_o),
        .res_ready_i       (res_ready_i),
        .res_tag_id_o      (res_tag_id_o),
        .res_found_o       (res_found_o),
        .res_index_o       (res_index_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    // CAM model: answers one cycle after the strobe; only tag 0x3D38 hits
    // (at index 7). Misses drive a nonzero index that must not leak out.
    initial begin
        forever begin
            @(negedge clk);
            cam_match_i = 1'b0;
            cam_index_i = 5'd0;
            if (pend) begin
                if (ptag == 32'h0000_3D38) begin
                    cam_match_i = 1'b1;
                    cam_index_i = 5'd7;
                end else begin
                    cam_match_i = 1'b0;
                    cam_index_i = 5'd5;
                end
            end
            pend = cam_search_o;
            ptag = cam_find_tag_o;
            if (cam_search_o) strobes++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_tag(input int idx, input logic [DW-1:0] d, input logic en);
        tag_wr_i = 1'b1;
        tag_wr_idx_i = TW'(idx);
        tag_wr_data_i = d;
        tag_wr_en_i = en;
        @(negedge clk);
        tag_wr_i = 1'b0;
        check_eq("wr_err_idle", tag_wr_err_o, 1'b0);
    endtask

    task automatic start_msg(input logic [AW-1:0] s, input logic [AW-1:0] e);
        check_eq("msg_ready", msg_ready_o, 1'b1);
        msg_valid_i = 1'b1;
        msg_start_i = s;
        msg_end_i = e;
        @(negedge clk);
        msg_valid_i = 1'b0;
    endtask

    task automatic wait_res(output int c);
        c = 0;
        while (res_valid_o !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_eq("res_valid", res_valid_o, 1'b1);
    endtask

    task automatic finish_lookup();
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check_eq("done_pulse", done_o, 1'b1);
        check_eq("res_valid_clr", res_valid_o, 1'b0);
        @(negedge clk);
        check_eq("done_end", done_o, 1'b0);
        check_eq("busy_end", busy_o, 1'b0);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", msg_ready_o, 1'b1);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_outs", {res_valid_o, cam_search_o, done_o, tag_wr_err_o}, 4'd0);
        check_eq("rst_tag", cam_find_tag_o, 32'd0);

        // Two enabled entries, hit then miss, with backpressure on the first
        wr_tag(0, 32'h0000_3D38, 1'b1);
        wr_tag(1, 32'h0000_3539, 1'b1);
        s0 = strobes;
        start_msg(5'd3, 5'd17);
        check_eq("a_strobe0", cam_search_o, 1'b1);
        check_eq("a_tag0", cam_find_tag_o, 32'h0000_3D38);
        check_eq("a_win0", {cam_start_index_o, cam_end_index_o}, {5'd3, 5'd17});
        check_eq("a_busy", {busy_o, msg_ready_o}, 2'b10);
        @(negedge clk);
        check_eq("a_idle_bus", {cam_search_o, cam_find_tag_o, cam_start_index_o, cam_end_index_o}, 43'd0);
        wait_res(cyc);
        check_eq("a_lat0", cyc, 1);
        check_eq("a_res0", {res_tag_id_o, res_found_o, res_index_o}, {3'd0, 1'b1, 5'd7});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("a_bp_hold", {res_valid_o, res_tag_id_o, res_found_o, res_index_o, cam_search_o},
                     {1'b1, 3'd0, 1'b1, 5'd7, 1'b0});
        end
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check_eq("a_strobe1", cam_search_o, 1'b1);
        check_eq("a_tag1", cam_find_tag_o, 32'h0000_3539);
        check_eq("a_win1", {cam_start_index_o, cam_end_index_o}, {5'd3, 5'd17});
        @(negedge clk);
        wait_res(cyc);
        check_eq("a_lat1", cyc, 1);
        check_eq("a_res1", {res_tag_id_o, res_found_o, res_index_o}, {3'd1, 1'b0, 5'd0});
        finish_lookup();
        check_eq("a_strobes", strobes - s0, 2);

        // Only entry 5 enabled; write during WAIT is dropped
        wr_tag(0, 32'h0000_3D38, 1'b0);
        wr_tag(1, 32'h0000_3539, 1'b0);
        wr_tag(5, 32'h0000_ABCD, 1'b1);
        s0 = strobes;
        start_msg(5'd0, 5'd31);
        check_eq("b_tag", cam_find_tag_o, 32'h0000_ABCD);
        @(negedge clk);
        check_eq("b_busy_wait", busy_o, 1'b1);
        tag_wr_i = 1'b1;
        tag_wr_idx_i = 3'd5;
        tag_wr_data_i = 32'h0000_1111;
        tag_wr_en_i = 1'b1;
        @(negedge clk);
        tag_wr_i = 1'b0;
        check_eq("b_wr_err", tag_wr_err_o, 1'b1);
        check_eq("b_res", {res_valid_o, res_tag_id_o, res_found_o, res_index_o}, {1'b1, 3'd5, 1'b0, 5'd0});
        finish_lookup();
        check_eq("b_err_pulse", tag_wr_err_o, 1'b0);
        check_eq("b_strobes", strobes - s0, 1);

        // Write coincident with acceptance is dropped; table unchanged
        check_eq("c_ready", msg_ready_o, 1'b1);
        msg_valid_i = 1'b1;
        msg_start_i = 5'd1;
        msg_end_i = 5'd9;
        tag_wr_i = 1'b1;
        tag_wr_idx_i = 3'd5;
        tag_wr_data_i = 32'h0000_2222;
        @(negedge clk);
        msg_valid_i = 1'b0;
        tag_wr_i = 1'b0;
        check_eq("c_wr_err", tag_wr_err_o, 1'b1);
        check_eq("c_tag", cam_find_tag_o, 32'h0000_ABCD);
        @(negedge clk);
        wait_res(cyc);
        check_eq("c_res_id", res_tag_id_o, 3'd5);
        finish_lookup();

        // No entries enabled
        wr_tag(5, 32'h0000_ABCD, 1'b0);
        s0 = strobes;
        start_msg(5'd1, 5'd2);
        check_eq("d_cyc1", {busy_o, done_o, cam_search_o}, 3'b100);
        @(negedge clk);
        check_eq("d_done", done_o, 1'b1);
        @(negedge clk);
        check_eq("d_after", {done_o, busy_o, msg_ready_o}, 3'b001);
        check_eq("d_strobes", strobes - s0, 0);

        // Reset during WAIT, then a wrapped window
        wr_tag(2, 32'h0000_0077, 1'b1);
        start_msg(5'd9, 5'd10);
        check_eq("e_tag", cam_find_tag_o, 32'h0000_0077);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("e_rst_outs", {busy_o, res_valid_o, cam_search_o, done_o}, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("e_quiet", {done_o, res_valid_o, cam_search_o, busy_o}, 4'd0);
        end
        wr_tag(3, 32'h0000_0055, 1'b1);
        start_msg(5'd20, 5'd4);
        check_eq("e_win", {cam_start_index_o, cam_end_index_o}, {5'd20, 5'd4});
        check_eq("e_tag2", cam_find_tag_o, 32'h0000_0055);
        @(negedge clk);
        wait_res(cyc);
        check_eq("e_res", {res_tag_id_o, res_found_o, res_index_o}, {3'd3, 1'b0, 5'd0});
        finish_lookup();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
